// File: rtl/store_aligner.sv
// Store-path byte-lane packer: replicates sb/sh/sw data across the word, builds
// little-endian byte enables and runs a req/ack write with timeout to data memory.
module store_aligner #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_done,
  output logic        st_fault,
  output logic [1:0]  st_cause,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] C_NONE     = 2'b00;
  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_ILLEGAL  = 2'b10;
  localparam logic [1:0] C_TIMEOUT  = 2'b11;
  localparam logic [7:0] LP_LAST    = 8'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_done;
  logic        r_fault;
  logic [1:0]  r_cause;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [1:0]  w_cause;

  // Illegal size is decided before alignment so size 11 always reports cause 10.
  always_comb begin
    w_be    = '0;
    w_wdata = st_data;
    w_cause = C_NONE;
    case (st_size)
      2'b00: begin
        w_be    = 4'b0001 << st_addr[1:0];
        w_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        w_be    = st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data[15:0]}};
        if (st_addr[0]) w_cause = C_MISALIGN;
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = st_data;
        if (st_addr[1:0] != 2'b00) w_cause = C_MISALIGN;
      end
      default: w_cause = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_cause     <= C_NONE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= C_NONE;
      case (r_state)
        S_IDLE: begin
          if (st_valid) begin
            if (w_cause != C_NONE) begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
              r_cause <= w_cause;
            end else begin
              r_state     <= S_REQ;
              r_cnt       <= '0;
              r_mem_req   <= 1'b1;
              r_mem_addr  <= {st_addr[31:2], 2'b00};
              r_mem_wdata <= w_wdata;
              r_mem_be    <= w_be;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_mem_req <= 1'b0;
            r_mem_be  <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state   <= S_FAULT;
            r_fault   <= 1'b1;
            r_cause   <= C_TIMEOUT;
            r_mem_req <= 1'b0;
            r_mem_be  <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_FAULT: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign st_ready  = (r_state == S_IDLE) && !rst;
  assign st_done   = r_done;
  assign st_fault  = r_fault;
  assign st_cause  = r_cause;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule
